// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, init ROM and cycle-derivation helpers for the LCD sequencer
package lcd_pkg;

   typedef enum logic [2:0] {PWRUP, INIT_NIB, INIT_WAIT, IDLE, SETUP, PULSE, HOLD, WAIT} state_e;
   typedef enum logic [1:0] {W_SHORT, W_LONG, W_INIT1, W_INIT2} wsel_e;

   localparam int INIT_STEPS = 8;
   localparam logic [7:0] CLR = 8'h01;
   localparam logic [7:0] HOME = 8'h02;

   // Steps 0-3 are single nibbles, steps 4-7 are full bytes
   localparam logic [3:0] INIT_NIBS [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
   localparam wsel_e INIT_WSEL [4] = '{W_INIT1, W_INIT2, W_INIT2, W_SHORT};
   localparam logic [7:0] INIT_BYTES [4] = '{8'h28, 8'h0C, 8'h06, CLR};

   function automatic int cyc(input longint rate, input longint ns);
      longint c;
      c = (rate * ns + 64'd999_999_999) / 64'd1_000_000_000;
      return (c < 1) ? 1 : int'(c);
   endfunction

   // Clear and home need the long execution delay
   function automatic logic is_long(input logic rs, input logic [7:0] d);
      return !rs && d[7:2] == 6'd0 && d != 8'd0;
   endfunction

endpackage

// File: rtl/lcd_seq_ctrl_timer.sv
// lcd_delay_timer: loadable down-counter shared by all timed sequencer states
module lcd_delay_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         done
);

   always_ff @(posedge clk) begin
      if (load) value <= load_val;
      else if (value != '0) value <= value - 1'b1;
   end

   assign done = value == '0;

endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: HD44780 4-bit bus sequencer with power-on init and byte handshake
module lcd_seq_ctrl
   import lcd_pkg::*;
#(
   parameter int CLOCK_RATE = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       init_done,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic [3:0] lcd_data
);

   localparam int EN_CYC    = cyc(CLOCK_RATE, 1_000);
   localparam int SHORT_CYC = cyc(CLOCK_RATE, 50_000);
   localparam int LONG_CYC  = cyc(CLOCK_RATE, 2_000_000);
   localparam int PWRUP_CYC = cyc(CLOCK_RATE, 50_000_000);
   localparam int INIT_W1   = cyc(CLOCK_RATE, 5_000_000);
   localparam int INIT_W2   = cyc(CLOCK_RATE, 1_000_000);
   localparam int W         = $clog2(PWRUP_CYC + 1);

   state_e state, state_n, nxt;
   logic [2:0] step;
   logic nib_low, cur_rs;
   logic [7:0] cur_byte;
   logic go_byte, go_low, go_nib, step_inc, done_set, init_nib;
   logic nb_rs;
   logic [7:0] nb_byte;
   logic [3:0] nn_val;
   logic t_load, t_done;
   logic [W-1:0] t_val, unused_value;

   function automatic logic [W-1:0] wait_val(input wsel_e s);
      return s == W_LONG  ? W'(LONG_CYC - 1) :
             s == W_INIT1 ? W'(INIT_W1 - 1)  :
             s == W_INIT2 ? W'(INIT_W2 - 1)  : W'(SHORT_CYC - 1);
   endfunction

   assign req_ready = state == IDLE && init_done;
   assign init_nib  = !init_done && !step[2];

   always_comb begin
      state_n  = state;
      go_byte  = 1'b0;
      go_low   = 1'b0;
      go_nib   = 1'b0;
      step_inc = 1'b0;
      done_set = 1'b0;
      nb_rs    = 1'b0;
      nb_byte  = '0;
      nn_val   = '0;
      case (state)
         PWRUP: if (t_done) begin
            state_n = INIT_NIB;
            go_nib  = 1'b1;
            nn_val  = INIT_NIBS[step[1:0]];
         end
         INIT_NIB, SETUP: state_n = PULSE;
         PULSE: state_n = t_done ? HOLD : PULSE;
         HOLD: begin
            state_n = init_nib ? INIT_WAIT : nib_low ? WAIT : SETUP;
            go_low  = !init_nib && !nib_low;
         end
         INIT_WAIT: if (t_done) begin
            step_inc = 1'b1;
            if (step[1:0] == 2'd3) begin
               state_n = SETUP;
               go_byte = 1'b1;
               nb_byte = INIT_BYTES[0];
            end else begin
               state_n = INIT_NIB;
               go_nib  = 1'b1;
               nn_val  = INIT_NIBS[step[1:0] + 2'd1];
            end
         end
         WAIT: if (t_done) begin
            if (init_done || step == 3'd7) begin
               state_n  = IDLE;
               done_set = !init_done;
            end else begin
               state_n  = SETUP;
               step_inc = 1'b1;
               go_byte  = 1'b1;
               nb_byte  = INIT_BYTES[step[1:0] + 2'd1];
            end
         end
         IDLE: if (req_valid && req_ready) begin
            state_n = SETUP;
            go_byte = 1'b1;
            nb_rs   = req_rs;
            nb_byte = req_data;
         end
         default: state_n = PWRUP;
      endcase
   end

   // The timer is reloaded on every state change and throughout reset
   always_comb begin
      nxt    = reset ? PWRUP : state_n;
      t_load = reset || state_n != state;
      t_val  = nxt == PWRUP     ? W'(PWRUP_CYC - 1) :
               nxt == PULSE     ? W'(EN_CYC - 1) :
               nxt == INIT_WAIT ? wait_val(INIT_WSEL[step[1:0]]) :
               nxt == WAIT      ? wait_val(is_long(cur_rs, cur_byte) ? W_LONG : W_SHORT) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= PWRUP;
         step      <= '0;
         init_done <= 1'b0;
         nib_low   <= 1'b0;
         cur_rs    <= 1'b0;
         cur_byte  <= '0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= '0;
      end else begin
         state  <= state_n;
         lcd_en <= state_n == PULSE;
         if (step_inc) step <= step + 3'd1;
         if (done_set) init_done <= 1'b1;
         if (go_byte) begin
            cur_rs   <= nb_rs;
            cur_byte <= nb_byte;
            nib_low  <= 1'b0;
            lcd_rs   <= nb_rs;
            lcd_data <= nb_byte[7:4];
         end
         if (go_low) begin
            nib_low  <= 1'b1;
            lcd_rs   <= cur_rs;
            lcd_data <= cur_byte[3:0];
         end
         if (go_nib) begin
            lcd_rs   <= 1'b0;
            lcd_data <= nn_val;
         end
      end
   end

   lcd_delay_timer #(.W(W)) u_timer (
      .clk      (clk),
      .load     (t_load),
      .load_val (t_val),
      .value    (unused_value),
      .done     (t_done)
   );

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: directed self-checking bench for lcd_seq_ctrl at CLOCK_RATE=1000
module tb_lcd_seq_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req_valid = 1'b0;
   logic req_rs = 1'b0;
   logic [7:0] req_data = '0;
   logic req_ready, init_done, lcd_en, lcd_rs;
   logic [3:0] lcd_data;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic en_prev = 1'b0;
   logic early_ready = 1'b0;
   logic [4:0] log_q[$];
   int rise_t[$];

   lcd_seq_ctrl #(.CLOCK_RATE(1000)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .init_done (init_done),
      .lcd_en    (lcd_en),
      .lcd_rs    (lcd_rs),
      .lcd_data  (lcd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log {rs,data} at every enable rising edge
   always @(negedge clk) begin
      if (lcd_en && !en_prev) begin
         log_q.push_back({lcd_rs, lcd_data});
         rise_t.push_back(cyc);
      end
      if (req_ready && !init_done) early_ready = 1'b1;
      en_prev = lcd_en;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic rs, input logic [7:0] d, output int n);
      req_rs = rs;
      req_data = d;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin
         n++;
         tick();
      end
   endtask

   task automatic chk_init(input int base);
      logic [4:0] exp_init [12];
      exp_init = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
      chk("init_count", log_q.size(), base + 12);
      for (int i = 0; i < 12; i++) chk($sformatf("init_nib%0d", i), log_q[base + i], exp_init[i]);
   endtask

   initial begin
      int n, base;
      int t[3];
      logic saw;
      logic [7:0] bb [3];
      bb = '{8'h48, 8'h49, 8'h21};
      // Byte 0x41 is held valid through init and must wait for ready
      req_valid = 1'b1;
      req_rs = 1'b1;
      req_data = 8'h41;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_en", lcd_en, 0);
      chk("rst_rs_data", {lcd_rs, lcd_data}, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_init_done", init_done, 0);
      saw = 1'b0;
      repeat (50) begin
         tick();
         saw |= lcd_en;
      end
      chk("pwrup_quiet", saw, 0);
      chk("first_setup", {lcd_en, lcd_rs, lcd_data}, 6'h03);
      tick();
      chk("first_pulse", lcd_en, 1);
      tick();
      chk("first_hold", {lcd_en, lcd_data}, 5'h03);
      n = 0;
      while (!lcd_en && n < 50) begin
         tick();
         n++;
      end
      // HOLD + 5 init-wait cycles + SETUP between pulses
      chk("pulse_gap", n, 7);
      n = 0;
      while (!init_done && n < 200) begin
         tick();
         n++;
      end
      chk("init_done_seen", init_done, 1);
      chk("init_done_lat", cyc - rise_t[rise_t.size() - 1], 4);
      chk("ready_after_init", req_ready, 1);
      chk("no_early_ready", early_ready, 0);
      chk_init(0);
      tick();
      req_valid = 1'b0;
      chk("data_setup", {lcd_en, lcd_rs, lcd_data}, 6'h14);
      chk("ready_drop", req_ready, 0);
      n = 0;
      while (!req_ready && n < 50) begin
         n++;
         tick();
      end
      chk("data_low_len", n, 7);
      chk("data_hi", log_q[12], 5'h14);
      chk("data_lo", log_q[13], 5'h11);
      send(1'b0, 8'h01, n);
      chk("clr_len", n, 8);
      chk("clr_hi", log_q[14], 5'h00);
      chk("clr_lo", log_q[15], 5'h01);
      send(1'b0, 8'h28, n);
      chk("fnset_len", n, 7);
      send(1'b1, 8'h01, n);
      chk("data01_len", n, 7);
      send(1'b0, 8'h02, n);
      chk("home_len", n, 8);
      send(1'b0, 8'h04, n);
      chk("entry_len", n, 7);
      send(1'b0, 8'h00, n);
      chk("zero_len", n, 7);
      chk("single_count", log_q.size(), 26);
      base = log_q.size();
      req_valid = 1'b1;
      req_rs = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_data = bb[i];
         n = 0;
         while (!req_ready && n < 50) begin
            tick();
            n++;
         end
         t[i] = cyc;
         tick();
      end
      req_valid = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin
         n++;
         tick();
      end
      chk("b2b_period0", t[1] - t[0], 8);
      chk("b2b_period1", t[2] - t[1], 8);
      chk("b2b_count", log_q.size(), base + 6);
      chk("b2b_nibs", {log_q[base], log_q[base+1], log_q[base+2], log_q[base+3], log_q[base+4], log_q[base+5]},
          {5'h14, 5'h18, 5'h14, 5'h19, 5'h12, 5'h11});
      req_rs = 1'b1;
      req_data = 8'h55;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("abort_pulse", lcd_en, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_en", lcd_en, 0);
      chk("abort_data", lcd_data, 0);
      chk("abort_init_done", init_done, 0);
      chk("abort_ready", req_ready, 0);
      base = log_q.size();
      n = 0;
      while (!lcd_en && n < 100) begin
         tick();
         n++;
      end
      chk("reinit_first_en", n, 51);
      n = 0;
      while (!init_done && n < 200) begin
         tick();
         n++;
      end
      chk("reinit_done", init_done, 1);
      chk("reinit_done_lat", cyc - rise_t[rise_t.size() - 1], 4);
      chk_init(base);
      repeat (20) tick();
      chk("no_resend", log_q.size(), base + 12);
      chk("final_ready", req_ready, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
